// File: rtl/fifo_rd_stream.sv
// Pulls words from a FIFO with a registered 1-cycle read port and presents them on a
// valid/ready stream through a 2-entry buffer, sustaining one word per cycle.
module fifo_rd_stream #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] fifo_rdata,
   input  logic             fifo_empty,
   output logic             fifo_re,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      word_cnt
);

   logic [1:0]       occ_q, occ_d;
   logic             inflight_q, inflight_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             pop;
   logic [1:0]       occ_after_pop;
   logic [2:0]       level;

   always_comb begin
      pop           = (occ_q != 2'd0) & m_ready;
      occ_after_pop = occ_q - {1'b0, pop};
      // Words committed after this edge: buffered plus the one arriving, minus the one leaving.
      level         = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_re       = ~fifo_empty & rst_n & (level < 3'd2);

      head_d = head_q;
      tail_d = tail_q;
      if (pop && (occ_q == 2'd2)) begin
         head_d = tail_q;
      end
      // The arriving word lands behind whatever survives this edge's pop.
      if (inflight_q) begin
         if (occ_after_pop == 2'd0) begin
            head_d = fifo_rdata;
         end else begin
            tail_d = fifo_rdata;
         end
      end

      occ_d      = level[1:0];
      inflight_d = fifo_re;
      cnt_d      = cnt_q + {15'd0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= 16'd0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
      end
   end

   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = head_q;
   assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a FIFO model with a registered read port feeds the DUT and
// a scoreboard queue holds the words expected on the output stream, in write order.
module tb_fifo_rd_stream;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] fifo_rdata = '0;
   logic         fifo_empty;
   logic         fifo_re;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic [15:0]  word_cnt;

   int total = 0;
   int bad = 0;
   logic [W-1:0] sb[$];

   logic [W-1:0] mem [0:4095];
   int wr_ptr = 0;
   int rd_ptr = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_re) begin
         fifo_rdata <= mem[rd_ptr % 4096];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   fifo_rd_stream #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
      .fifo_re(fifo_re), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .word_cnt(word_cnt)
   );

   task automatic fifo_write(input logic [W-1:0] v, input bit expect_out);
      mem[wr_ptr % 4096] = v;
      wr_ptr++;
      if (expect_out) sb.push_back(v);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
      total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL reset_re got=%b want=0", fifo_re); end
      total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", word_cnt); end
      total++; if (m_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", m_data); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset: released");
   endtask

   task automatic test_stream();
      int re_n, first_re, first_v, last_v, got;
      logic [W-1:0] exp;
      re_n = 0; first_re = -1; first_v = -1; last_v = -1; got = 0;
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) fifo_write(W'(i), 1'b1);
      for (int c = 0; c < 20; c++) begin
         #1;
         if (fifo_re) begin
            re_n++;
            if (first_re < 0) first_re = c;
         end
         if (m_valid && m_ready) begin
            if (first_v < 0) first_v = c;
            last_v = c;
            got++;
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL stream_data got=%h want=%h", m_data, exp); end
            else $display("stream: word %h at cycle %0d", m_data, c);
         end
         @(negedge clk);
      end
      total++; if (re_n != 8) begin bad++; $display("FAIL stream_re_cycles got=%0d want=8", re_n); end
      total++; if (first_v - first_re != 2) begin bad++; $display("FAIL stream_latency got=%0d want=2", first_v - first_re); end
      total++; if (got != 8 || last_v - first_v != 7) begin bad++; $display("FAIL stream_burst got=%0d span=%0d want=8 span=7", got, last_v - first_v); end
      total++; if (word_cnt !== 16'd8) begin bad++; $display("FAIL stream_cnt got=%0d want=8", word_cnt); end
   endtask

   task automatic test_backpressure();
      int re_n, first_v, last_v, got;
      logic [W-1:0] exp;
      bit held;
      re_n = 0; first_v = -1; last_v = -1; got = 0; held = 1'b1;
      m_ready = 1'b0;
      for (int i = 'hA; i <= 'hE; i++) fifo_write(W'(i), 1'b1);
      for (int c = 0; c < 10; c++) begin
         #1;
         if (fifo_re) re_n++;
         if (c >= 3 && (m_valid !== 1'b1 || m_data !== W'(32'hA))) held = 1'b0;
         @(negedge clk);
      end
      total++; if (re_n != 2) begin bad++; $display("FAIL stall_reads got=%0d want=2", re_n); end
      total++; if (!held) begin bad++; $display("FAIL stall_hold got=%h/%b want=0000000a/1", m_data, m_valid); end
      m_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (m_valid && m_ready) begin
            if (first_v < 0) first_v = c;
            last_v = c;
            got++;
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL stall_data got=%h want=%h", m_data, exp); end
            else $display("stall: word %h at cycle %0d", m_data, c);
         end
         @(negedge clk);
      end
      total++; if (got != 5 || last_v - first_v != 4) begin bad++; $display("FAIL stall_burst got=%0d span=%0d want=5 span=4", got, last_v - first_v); end
      total++; if (word_cnt !== 16'd13) begin bad++; $display("FAIL stall_cnt got=%0d want=13", word_cnt); end
   endtask

   task automatic test_random();
      int written, got, c, bad_before;
      logic prev_valid, prev_pop;
      logic [W-1:0] prev_data, exp;
      written = 0; got = 0; c = 0; prev_valid = 1'b0; prev_pop = 1'b0; prev_data = '0;
      bad_before = bad;
      while (got < 1000 && c < 20000) begin
         if (written < 1000 && $urandom_range(0, 1) == 1) begin
            fifo_write($urandom(), 1'b1);
            written++;
         end
         m_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (prev_valid && !prev_pop) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               bad++; $display("FAIL rand_hold got=%h/%b want=%h/1", m_data, m_valid, prev_data);
            end
         end
         if (fifo_empty && fifo_re) begin
            total++; bad++; $display("FAIL rand_re_empty got=1 want=0");
         end
         if (m_valid && m_ready) begin
            got++;
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL rand_data got=%h want=%h", m_data, exp); end
         end
         prev_valid = m_valid;
         prev_pop = m_valid & m_ready;
         prev_data = m_data;
         c++;
         @(negedge clk);
      end
      m_ready = 1'b0;
      total++; if (got != 1000) begin bad++; $display("FAIL rand_count got=%0d want=1000", got); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", sb.size()); end
      total++; if (word_cnt !== 16'd1013) begin bad++; $display("FAIL rand_cnt got=%0d want=1013", word_cnt); end
      $display("random: %0d words in %0d cycles, new failures %0d", got, c, bad - bad_before);
   endtask

   task automatic test_drain();
      logic [W-1:0] exp;
      m_ready = 1'b1;
      fifo_write(W'(32'h77), 1'b1);
      #1;
      total++; if (fifo_re !== 1'b1) begin bad++; $display("FAIL drain_re0 got=%b want=1", fifo_re); end
      @(negedge clk); #1;
      total++; if (fifo_empty !== 1'b1 || fifo_re !== 1'b0) begin bad++; $display("FAIL drain_re_empty got=%b want=0", fifo_re); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drain_early_valid got=%b want=0", m_valid); end
      @(negedge clk); #1;
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      total++; if (m_valid !== 1'b1 || m_data !== exp) begin bad++; $display("FAIL drain_word got=%h/%b want=%h/1", m_data, m_valid, exp); end
      else $display("drain: word %h delivered", m_data);
      @(negedge clk); #1;
      total++; if (m_valid !== 1'b0 || fifo_re !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b/%b want=0/0", m_valid, fifo_re); end
      total++; if (word_cnt !== 16'd1014) begin bad++; $display("FAIL drain_cnt got=%0d want=1014", word_cnt); end
   endtask

   task automatic test_reset_midstream();
      int got;
      logic [W-1:0] exp;
      got = 0;
      m_ready = 1'b0;
      fifo_write(W'(32'h50), 1'b0);
      fifo_write(W'(32'h51), 1'b0);
      fifo_write(W'(32'h52), 1'b1);
      fifo_write(W'(32'h53), 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", m_valid); end
      total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", word_cnt); end
      total++; if (fifo_re !== 1'b0) begin bad++; $display("FAIL rstmid_re got=%b want=0", fifo_re); end
      repeat (2) @(negedge clk);
      total++; if (wr_ptr - rd_ptr != 2) begin bad++; $display("FAIL rstmid_pops got=%0d want=2", wr_ptr - rd_ptr); end
      rst_n = 1'b1;
      m_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (m_valid && m_ready) begin
            got++;
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            total++;
            if (m_data !== exp) begin bad++; $display("FAIL rstmid_data got=%h want=%h", m_data, exp); end
            else $display("rstmid: word %h after release", m_data);
         end
         @(negedge clk);
      end
      total++; if (got != 2) begin bad++; $display("FAIL rstmid_words got=%0d want=2", got); end
      total++; if (word_cnt !== 16'd2) begin bad++; $display("FAIL rstmid_cnt2 got=%0d want=2", word_cnt); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_drain();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
